// File: rtl/t02_regfile_sb_if.sv
// rtl/t02_regfile_sb_if.sv - decode/writeback bus of the t02 scoreboarded register file
// Master is the pipeline side (decode + writeback), slave is the register file.
interface t02_regfile_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                       en;
  logic                       wr_en;
  logic [IDX_W-1:0]           wr_idx;
  logic [DATA_W-1:0]          wr_data;
  logic                       rsv_en;
  logic [IDX_W-1:0]           rsv_idx;
  logic [NUM_RD*IDX_W-1:0]    rd_idx;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_pend;
  logic [IDX_W:0]             pend_cnt;

  modport master (
    output en, wr_en, wr_idx, wr_data, rsv_en, rsv_idx, rd_idx,
    input  rd_data, rd_pend, pend_cnt
  );

  modport slave (
    input  en, wr_en, wr_idx, wr_data, rsv_en, rsv_idx, rd_idx,
    output rd_data, rd_pend, pend_cnt
  );
endinterface

// File: rtl/t02_regfile_sb.sv
// rtl/t02_regfile_sb.sv - parametrised register file with per-register pending bits and pending count
// Optional write-through forwarding to the read ports: define T02_RF_BYPASS_EN.
module t02_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              nRST,
  t02_regfile_sb_if.slave   bus
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             pend_q, pend_d;
  logic [IDX_W:0]                  pend_cnt_q, pend_cnt_d;

  logic                            wr_ok;
  logic                            rsv_ok;
  logic                            pend_set;
  logic                            pend_clr;
  logic [IDX_W-1:0]                rd_sel;
  logic [NUM_RD*DATA_W-1:0]        rd_data_c;
  logic [NUM_RD-1:0]               rd_pend_c;

  // Index exists and is not the hardwired zero register.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_W) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    wr_ok    = bus.en & bus.wr_en & idx_ok(bus.wr_idx);
    rsv_ok   = bus.en & bus.rsv_en & idx_ok(bus.rsv_idx);
    regs_d   = regs_q;
    pend_d   = pend_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;

    if (wr_ok) begin
      regs_d[bus.wr_idx] = bus.wr_data;
      pend_d[bus.wr_idx] = 1'b0;
      pend_clr           = pend_q[bus.wr_idx];
    end

    // Reserve is applied after the write so a same-index pair leaves the bit set.
    if (rsv_ok) begin
      pend_d[bus.rsv_idx] = 1'b1;
      pend_set            = ~pend_q[bus.rsv_idx];
      if (wr_ok && (bus.wr_idx == bus.rsv_idx)) begin
        pend_clr = 1'b0;
      end
    end

    pend_cnt_d = pend_cnt_q + {{IDX_W{1'b0}}, pend_set} - {{IDX_W{1'b0}}, pend_clr};
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      regs_q     <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    rd_sel    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_sel = bus.rd_idx[p*IDX_W +: IDX_W];
      if (idx_ok(rd_sel)) begin
        rd_data_c[p*DATA_W +: DATA_W] = regs_q[rd_sel];
        rd_pend_c[p]                  = pend_q[rd_sel];
      end
`ifdef T02_RF_BYPASS_EN
      if (wr_ok && (bus.wr_idx == rd_sel)) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.wr_data;
        rd_pend_c[p]                  = 1'b0;
      end
`else
`endif
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_pend  = rd_pend_c;
  assign bus.pend_cnt = pend_cnt_q;
endmodule
